// File: rtl/fsm_input_conditioner.sv
// Input conditioning for the control FSM: synchronises and debounces the raw
// A6/X3/I3 condition lines and flags every accepted level change.

module fsm_ic_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic fall,
    output logic flip,
    output logic idle
);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s    = sync[SYNC_STAGES-1];
    // The flip edge both accepts the new level and clears the counter, so it never wraps.
    assign flip = (s != q) && (cnt == CNT_W'(DEB_CYCLES - 1));
    assign idle = (s == q) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (s == q || flip)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (flip)
                q <= s;
            rise <= flip & s;
            fall <= flip & ~s;
        end
    end
endmodule

module fsm_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       a6_raw,
    input  logic       x3_raw,
    input  logic       i3_raw,
    output logic       A6,
    output logic       X3,
    output logic       I3,
    output logic [2:0] rise,
    output logic [2:0] fall,
    output logic       chg,
    output logic       stable
);
    logic [2:0] raw;
    logic [2:0] q;
    logic [2:0] flip;
    logic [2:0] idle;

    assign raw = {a6_raw, x3_raw, i3_raw};

    fsm_ic_lane #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane [2:0] (
        .clk  (clk),
        .rst_b(rst_b),
        .raw  (raw),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .flip (flip),
        .idle (idle)
    );

    // Registered off the same flip terms as rise/fall so all three pulse together.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            chg <= 1'b0;
        else
            chg <= |flip;
    end

    assign {A6, X3, I3} = q;
    assign stable       = &idle;
endmodule
